pmcd_divgen: RTL and testbench
==============================

Name: pmcd_divgen

Overview:
- Parametrised, single-clock successor to the fixed phase-matched clock divider.
- Produces phase-aligned binary-divided clocks (/2 … /2^DIV_STAGES), each with a one-cycle enable pulse.
- Adds a runtime-programmable divide-by-N channel whose rising edges align with the binary channels.
- Optional release gating (EN_REL) holds all outputs idle after reset until REL is seen.
- Sits in the clock-management area and feeds fabric logic that needs coherent slow clocks and enables.

Parameters:
- DIV_STAGES, 3, number of binary divide outputs (legal 1..8); CLKD[k] divides by 2^(k+1).
- DIV_W, 8, width of the programmable divisor input DIV.
- EN_REL, "FALSE", "TRUE" means outputs start only after REL is sampled high following reset; any other value means outputs start immediately.

Ports:
- CLK  input  1  sole clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- REL  input  1  release request; sampled only in WAIT_REL state.
- DIV  input  DIV_W  programmable divisor for CLKP; values 0 and 1 disable CLKP.
- CLKD  output  DIV_STAGES  binary-divided clocks, registered.
- CE  output  DIV_STAGES  CE[k] is a one-cycle pulse in the cycle CLKD[k] goes 0→1.
- CLKP  output  1  programmable-divided clock, registered.
- CLKP_CE  output  1  one-cycle pulse in the cycle CLKP goes 0→1.
- RUN  output  1  high while the FSM is in RUN.

Behaviour:
- Reset: RST=1 at an edge puts the FSM in HOLD and clears cnt, pcnt, CLKD, CE, CLKP, CLKP_CE and RUN to 0. RST mid-operation takes effect at the next edge and aborts any partial period.
- FSM states: HOLD, WAIT_REL, RUN.
  - HOLD→WAIT_REL if EN_REL=="TRUE", else HOLD→RUN, on the first edge with RST=0.
  - WAIT_REL→RUN on an edge with REL=1.
  - RUN stays in RUN until RST.
  - REL is ignored outside WAIT_REL. RST has priority over REL.
- RUN is the registered state decode. In the cycle RUN first reads 1, cnt=0 and pcnt=0.
- Binary channels:
  - cnt is DIV_STAGES bits. It increments by 1 each edge while in RUN and wraps modulo 2^DIV_STAGES; it is held at 0 otherwise.
  - CLKD[k] = cnt[k] (direct register bits).
  - CE[k] <= rising edge of cnt_next[k], registered so that it coincides with CLKD[k]=1 in the first high cycle.
- Programmable channel:
  - div_l is the latched divisor. It loads DIV every cycle outside RUN, at each edge where pcnt wraps to 0, and every cycle while div_l<2.
  - In RUN with div_l≥2, pcnt counts 0..div_l-1 and then wraps.
  - CLKP <= (pcnt_next ≥ floor(div_l/2)), giving ceil(div_l/2) cycles high per period.
  - CLKP_CE pulses in CLKP's first high cycle.
  - A DIV change mid-period takes effect only at the next wrap.
  - With div_l<2: pcnt=0, CLKP=0, CLKP_CE=0.
- Phase alignment: for DIV=2^(k+1), CLKP and CLKP_CE equal CLKD[k] and CE[k] every cycle. Both channels first rise N/2 cycles after RUN entry.
- Latency: EN_REL="FALSE" gives RUN=1 one cycle after RST falls. EN_REL="TRUE" gives RUN=1 one cycle after the REL sample.
- Arithmetic: unsigned. The pcnt compare is done at DIV_W bits with no overflow, because pcnt < div_l ≤ 2^DIV_W-1.

Decomposition:
- Package pmcd_pkg holds:
  - the state enum (HOLD, WAIT_REL, RUN);
  - a function converting the EN_REL string to a bit;
  - DIV_STAGES bounds constants.
- One sub-module, pmcd_prog_div, contains pcnt, div_l, CLKP and CLKP_CE. It takes CLK, RST, a run enable and DIV.
- The top module holds the FSM and the binary counter.

Test Plan:
- EN_REL="FALSE", DIV_STAGES=3: release RST at cycle 0 → RUN=1 at cycle 1; CLKD[0] toggles from cycle 2; CLKD[2] pattern 0000_1111 repeating; CE[2] high only at cycles 5, 13, 21.
- EN_REL="TRUE": hold REL=0 for 20 cycles → all outputs 0 and RUN=0. Pulse REL for 1 cycle → RUN=1 on the next cycle, then the same sequence as the first scenario.
- DIV=4 vs DIV=8 with DIV_STAGES=3 → CLKP bit-identical to CLKD[1] and CLKD[2] respectively, and CLKP_CE identical to CE[1] and CE[2], over 64 cycles.
- DIV=5 → CLKP pattern 00111 repeating (2 low, 3 high). Change DIV to 3 mid-period → current period completes as 5, the next period is 011.
- DIV=0 then DIV=1 → CLKP=0 and CLKP_CE=0 throughout. Set DIV=6 → CLKP starts 000111 on the next cycle with the phase rule applied.
- Assert RST for 1 cycle in RUN, with REL=1 held in the same cycle → all outputs 0 next cycle. With EN_REL="TRUE", the FSM enters WAIT_REL and needs a fresh REL sampled after RST deasserts.

Source files
------------

// File: rtl/pmcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pmcd_pkg : shared types and helpers for the phase-matched divider family  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pmcd_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_WAIT_REL = 2'd1,
        ST_RUN      = 2'd2
    } pmcd_state_e;

    localparam int DIV_STAGES_MIN = 1;
    localparam int DIV_STAGES_MAX = 8;

    // Only the exact string "TRUE" enables release gating.
    function automatic bit en_rel_to_bit(input string s);
        return (s == "TRUE");
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmcd_prog_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pmcd_prog_div : runtime divide-by-N channel, rising edges aligned to the  |
// |                 binary channels of pmcd_divgen                             |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module pmcd_prog_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             clkp_o,
    output logic             clkp_ce_o
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

    logic [DIV_W-1:0] pcnt_q, pcnt_d;
    logic [DIV_W-1:0] div_l_q, div_l_d;
    logic             clkp_q, clkp_d;
    logic             clkp_ce_q, clkp_ce_d;
    logic             active;
    logic             wrap;

    // The divisor is only re-latched at period boundaries so a mid-period
    // DIV change never produces a runt pulse.
    always_comb begin
        active    = run_en_i && (div_l_q >= TWO);
        wrap      = active && (pcnt_q == (div_l_q - ONE));
        pcnt_d    = (!active || wrap) ? '0 : (pcnt_q + ONE);
        div_l_d   = (!active || wrap) ? div_i : div_l_q;
        clkp_d    = active && (pcnt_d >= (div_l_q >> 1));
        clkp_ce_d = clkp_d && !clkp_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q    <= '0;
            div_l_q   <= '0;
            clkp_q    <= 1'b0;
            clkp_ce_q <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            div_l_q   <= div_l_d;
            clkp_q    <= clkp_d;
            clkp_ce_q <= clkp_ce_d;
        end
    end

    assign clkp_o    = clkp_q;
    assign clkp_ce_o = clkp_ce_q;

endmodule
`default_nettype wire

// File: rtl/pmcd_divgen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pmcd_divgen : phase-matched binary clock divider with enables, optional   |
// |               release gating and a programmable divide-by-N channel        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module pmcd_divgen
    import pmcd_pkg::*;
#(
    parameter int    DIV_STAGES = 3,
    parameter int    DIV_W      = 8,
    parameter string EN_REL     = "FALSE"
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REL,
    input  logic [DIV_W-1:0]      DIV,
    output logic [DIV_STAGES-1:0] CLKD,
    output logic [DIV_STAGES-1:0] CE,
    output logic                  CLKP,
    output logic                  CLKP_CE,
    output logic                  RUN
);

    localparam bit                    REL_GATE = en_rel_to_bit(EN_REL);
    localparam logic [DIV_STAGES-1:0] CNT_ONE  = DIV_STAGES'(1);

    pmcd_state_e           state_q, state_d;
    logic [DIV_STAGES-1:0] cnt_q, cnt_d;
    logic [DIV_STAGES-1:0] ce_q, ce_d;
    logic                  run_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD:     state_d = REL_GATE ? ST_WAIT_REL : ST_RUN;
            ST_WAIT_REL: if (REL) state_d = ST_RUN;
            ST_RUN:      state_d = ST_RUN;
            default:     state_d = ST_HOLD;
        endcase
    end

    // CE is registered alongside cnt so it lands in the first high cycle.
    always_comb begin
        cnt_d = (state_q == ST_RUN) ? (cnt_q + CNT_ONE) : '0;
        ce_d  = cnt_d & ~cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            ce_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ce_q    <= ce_d;
            run_q   <= (state_d == ST_RUN);
        end
    end

    pmcd_prog_div #(
        .DIV_W (DIV_W)
    ) u_prog_div (
        .clk_i     (CLK),
        .rst_i     (RST),
        .run_en_i  (run_q),
        .div_i     (DIV),
        .clkp_o    (CLKP),
        .clkp_ce_o (CLKP_CE)
    );

    assign CLKD = cnt_q;
    assign CE   = ce_q;
    assign RUN  = run_q;

endmodule
`default_nettype wire

// File: tb/tb_pmcd_divgen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pmcd_divgen : scoreboard bench for pmcd_divgen, ungated and gated      |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pmcd_divgen;

    localparam int S = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rel = 1'b0;
    logic [W-1:0] div = W'(4);

    logic [S-1:0] clkd_f, ce_f, clkd_t, ce_t;
    logic         clkp_f, cep_f, run_f, clkp_t, cep_t, run_t;

    always #5 clk = ~clk;

    pmcd_divgen #(.DIV_STAGES(S), .DIV_W(W), .EN_REL("FALSE")) dut_f (
        .CLK(clk), .RST(rst), .REL(rel), .DIV(div),
        .CLKD(clkd_f), .CE(ce_f), .CLKP(clkp_f), .CLKP_CE(cep_f), .RUN(run_f)
    );

    pmcd_divgen #(.DIV_STAGES(S), .DIV_W(W), .EN_REL("TRUE")) dut_t (
        .CLK(clk), .RST(rst), .REL(rel), .DIV(div),
        .CLKD(clkd_t), .CE(ce_t), .CLKP(clkp_t), .CLKP_CE(cep_t), .RUN(run_t)
    );

    int checks = 0;
    int errors = 0;

    // Expected vector layout: {CLKD, CE, CLKP, CLKP_CE, RUN}
    logic [2*S+2:0] q0[$];
    logic [2*S+2:0] q1[$];

    // Reference model: 0 = held after reset, 1 = waiting for release, 2 = running
    int mode[2]  = '{0, 0};
    int t[2]     = '{0, 0};
    int plen[2]  = '{0, 0};
    int ph[2]    = '{0, 0};
    bit gate[2]  = '{1'b0, 1'b1};

    task automatic model_step(input int i, input bit r, input bit rl, input int d,
                              output logic [2*S+2:0] e);
        logic [S-1:0] cd;
        logic [S-1:0] c;
        logic         p;
        logic         pc;
        int           np;
        int           half;
        cd = '0; c = '0; p = 1'b0; pc = 1'b0;
        if (r) begin
            mode[i] = 0; t[i] = 0; ph[i] = 0; plen[i] = d;
        end else if (mode[i] == 2) begin
            t[i]++;
            for (int k = 0; k < S; k++) begin
                cd[k] = ((t[i] >> k) & 1) == 1;
                c[k]  = (t[i] % (2 << k)) == (1 << k);
            end
            if (plen[i] < 2) begin
                plen[i] = d; ph[i] = 0;
            end else begin
                half = plen[i] / 2;
                np   = ph[i] + 1;
                if (np == plen[i]) begin
                    np = 0; plen[i] = d;
                end
                ph[i] = np;
                p     = (np >= half) && (np != 0);
                pc    = (np == half);
            end
        end else begin
            plen[i] = d; ph[i] = 0;
            if (mode[i] == 0)  mode[i] = gate[i] ? 1 : 2;
            else if (rl)       mode[i] = 2;
            if (mode[i] == 2)  t[i] = 0;
        end
        e = {cd, c, p, pc, (mode[i] == 2)};
    endtask

    task automatic step(input bit r, input bit rl, input int d);
        logic [2*S+2:0] e;
        @(negedge clk);
        rst = r;
        rel = rl;
        div = W'(d);
        model_step(0, r, rl, d, e); q0.push_back(e);
        model_step(1, r, rl, d, e); q1.push_back(e);
    endtask

    task automatic run_for(input int n, input bit r, input bit rl, input int d);
        for (int j = 0; j < n; j++) step(r, rl, d);
    endtask

    task automatic check(input string nm, input logic [2*S+2:0] exp, input logic [2*S+2:0] act);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t act clkd=%b ce=%b clkp=%b cep=%b run=%b req clkd=%b ce=%b clkp=%b cep=%b run=%b",
                     nm, $time, act[2*S+2:S+3], act[S+2:3], act[2], act[1], act[0],
                     exp[2*S+2:S+3], exp[S+2:3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) check("ungated", q0.pop_front(), {clkd_f, ce_f, clkp_f, cep_f, run_f});
            if (q1.size() > 0) check("gated",   q1.pop_front(), {clkd_t, ce_t, clkp_t, cep_t, run_t});
        end
    end

    function automatic int pick_div();
        int sel;
        sel = int'($urandom_range(0, 3));
        case (sel)
            0:       return int'($urandom_range(0, 12));
            1:       return 2 << $urandom_range(0, 3);
            2:       return (($urandom_range(0, 1) == 0) ? 255 : 1);
            default: return int'($urandom_range(0, 40));
        endcase
    endfunction

    initial begin
        int d;
        bit r;
        bit rl;
        run_for(3, 1'b1, 1'b0, 4);
        // Ungated instance starts; gated one must stay idle without REL
        run_for(20, 1'b0, 1'b0, 4);
        step(1'b0, 1'b1, 4);
        run_for(64, 1'b0, 1'b0, 4);
        run_for(64, 1'b0, 1'b0, 8);
        run_for(12, 1'b0, 1'b0, 5);
        run_for(15, 1'b0, 1'b0, 3);
        run_for(10, 1'b0, 1'b0, 0);
        run_for(10, 1'b0, 1'b0, 1);
        run_for(20, 1'b0, 1'b0, 6);
        // Reset with REL high in the same cycle, then a fresh release
        step(1'b1, 1'b1, 6);
        run_for(10, 1'b0, 1'b0, 6);
        step(1'b0, 1'b1, 6);
        run_for(20, 1'b0, 1'b0, 6);
        d = 4;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 29) == 0) d = pick_div();
            r  = ($urandom_range(0, 149) == 0);
            rl = ($urandom_range(0, 7) == 0);
            step(r, rl, d);
        end
        @(posedge clk);
        #2;
        checks++;
        if (q0.size() + q1.size() != 0) begin
            errors++;
            $display("FAIL drain act pending=%0d req pending=0", q0.size() + q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
